// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: shares the console UART transmitter between the CPU teleprinter
// path and the debug message source, with one-character holding registers per source.
module serial_tx_arbiter #(
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_valid,
    input  logic [0:7] cpu_data,
    output logic       cpu_ready,
    input  logic       dbg_valid,
    input  logic [0:7] dbg_data,
    output logic       dbg_ready,
    output logic       tx_start,
    output logic [0:7] tx_data,
    input  logic       tx_busy,
    output logic       cpu_done,
    output logic       dbg_done,
    output logic       owner,
    output logic       tx_err
);

    localparam int BW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT_BUSY,
        WAIT_DONE,
        DONE,
        GAP
    } state_t;

    state_t        state;
    logic          cpu_full;
    logic          dbg_full;
    logic [0:7]    cpu_hold;
    logic [0:7]    dbg_hold;
    logic          last_grant;
    logic [BW-1:0] busy_cnt;
    logic [GW-1:0] gap_cnt;
    logic          pick_dbg;

    assign cpu_ready = !cpu_full;
    assign dbg_ready = !dbg_full;

    // Debug wins when it is the only one waiting, or on a tie when CPU went last.
    assign pick_dbg = dbg_full && (!cpu_full || !last_grant);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cpu_full   <= 1'b0;
            dbg_full   <= 1'b0;
            cpu_hold   <= '0;
            dbg_hold   <= '0;
            last_grant <= 1'b1;
            busy_cnt   <= '0;
            gap_cnt    <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            owner      <= 1'b0;
            cpu_done   <= 1'b0;
            dbg_done   <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            cpu_done <= 1'b0;
            dbg_done <= 1'b0;
            tx_err   <= 1'b0;

            if (cpu_valid && cpu_ready) begin
                cpu_hold <= cpu_data;
                cpu_full <= 1'b1;
            end
            if (dbg_valid && dbg_ready) begin
                dbg_hold <= dbg_data;
                dbg_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if ((cpu_full || dbg_full) && !tx_busy)
                        state <= SELECT;
                end
                SELECT: begin
                    if (pick_dbg) begin
                        tx_data  <= dbg_hold;
                        dbg_full <= 1'b0;
                    end else begin
                        tx_data  <= cpu_hold;
                        cpu_full <= 1'b0;
                    end
                    owner      <= pick_dbg;
                    last_grant <= pick_dbg;
                    tx_start   <= 1'b1;
                    busy_cnt   <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (busy_cnt == BW'(BUSY_TIMEOUT - 1)) begin
                        tx_err   <= 1'b1;
                        cpu_done <= !owner;
                        dbg_done <= owner;
                        state    <= DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        cpu_done <= !owner;
                        dbg_done <= owner;
                        state    <= DONE;
                    end
                end
                // The DONE cycle itself counts as the first gap clock.
                DONE: begin
                    if (GAP_CYCLES > 1) begin
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                        state   <= GAP;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GW'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter: arbitration table, multi-cycle corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_serial_tx_arbiter;

    localparam int GAP = 16;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_valid = 1'b0;
    logic [0:7] cpu_data = '0;
    logic       cpu_ready;
    logic       dbg_valid = 1'b0;
    logic [0:7] dbg_data = '0;
    logic       dbg_ready;
    logic       tx_start;
    logic [0:7] tx_data;
    logic       tx_busy;
    logic       cpu_done;
    logic       dbg_done;
    logic       owner;
    logic       tx_err;

    serial_tx_arbiter #(.GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_valid (cpu_valid),
        .cpu_data  (cpu_data),
        .cpu_ready (cpu_ready),
        .dbg_valid (dbg_valid),
        .dbg_data  (dbg_data),
        .dbg_ready (dbg_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .cpu_done  (cpu_done),
        .dbg_done  (dbg_done),
        .owner     (owner),
        .tx_err    (tx_err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for tx_len clocks after each launch, unless tied low.
    int tx_len = 5;
    bit tie_low = 1'b0;
    int busy_left = 0;

    always @(posedge clk) begin
        if (tx_start && !tie_low)
            busy_left <= tx_len;
        else if (busy_left > 0)
            busy_left <= busy_left - 1;
    end
    assign tx_busy = (busy_left > 0);

    // Event log sampled on the falling edge, away from the active edge.
    int         n_start = 0, n_cpu_done = 0, n_dbg_done = 0, n_err = 0;
    int         t_start = -1, t_cpu_done = -1, t_dbg_done = -1, t_err = -1;
    bit         start_owner;
    logic [0:7] start_data;

    always @(negedge clk) begin
        if (tx_start) begin
            n_start++;
            t_start     = cyc;
            start_owner = owner;
            start_data  = tx_data;
        end
        if (cpu_done) begin
            n_cpu_done++;
            t_cpu_done = cyc;
        end
        if (dbg_done) begin
            n_dbg_done++;
            t_dbg_done = cyc;
        end
        if (tx_err) begin
            n_err++;
            t_err = cyc;
        end
    end

    typedef struct {
        bit         cv;
        logic [0:7] cd;
        bit         dv;
        logic [0:7] dd;
        int         nl;
        bit         o0;
        logic [0:7] d0;
        bit         o1;
        logic [0:7] d1;
    } vec_t;

    vec_t vec [6];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expiredBound(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit cv, input logic [0:7] cd, input bit dv, input logic [0:7] dd);
        cpu_valid = cv;
        cpu_data  = cd;
        dbg_valid = dv;
        dbg_data  = dd;
        tick();
        cpu_valid = 1'b0;
        dbg_valid = 1'b0;
    endtask

    task automatic waitStarts(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_start < target && k < budget) begin
            tick();
            k++;
        end
        if (n_start < target) expiredBound(name);
    endtask

    task automatic waitCpuDone(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_cpu_done < target && k < budget) begin
            tick();
            k++;
        end
        if (n_cpu_done < target) expiredBound(name);
    endtask

    task automatic waitErr(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_err < target && k < budget) begin
            tick();
            k++;
        end
        if (n_err < target) expiredBound(name);
    endtask

    task automatic waitQuiet(input string name);
        int k;
        k = 0;
        while ((n_cpu_done + n_dbg_done) < n_start && k < 500) begin
            tick();
            k++;
        end
        if ((n_cpu_done + n_dbg_done) < n_start) expiredBound(name);
        repeat (GAP + 6) tick();
    endtask

    int         k0, s0, c0, d0, e0, td;
    logic [0:7] cpu_q[$];
    logic [0:7] dbg_q[$];
    bit         done_own_q[$];
    int         done_cyc_q[$];
    bit         both_prev, prev_owner;
    int         last_done;
    logic [0:7] exp_data;

    initial begin
        vec[0] = '{1'b1, 8'o101, 1'b1, 8'o102, 2, 1'b0, 8'o101, 1'b1, 8'o102};
        vec[1] = '{1'b0, 8'o000, 1'b1, 8'o055, 1, 1'b1, 8'o055, 1'b0, 8'o000};
        vec[2] = '{1'b1, 8'o033, 1'b1, 8'o044, 2, 1'b0, 8'o033, 1'b1, 8'o044};
        vec[3] = '{1'b1, 8'o252, 1'b0, 8'o000, 1, 1'b0, 8'o252, 1'b0, 8'o000};
        vec[4] = '{1'b1, 8'o111, 1'b1, 8'o222, 2, 1'b1, 8'o222, 1'b0, 8'o111};
        vec[5] = '{1'b1, 8'o377, 1'b1, 8'o000, 2, 1'b1, 8'o000, 1'b0, 8'o377};

        // Reset held with a CPU character offered: nothing may be captured or launched.
        reset     = 1'b0;
        cpu_valid = 1'b1;
        cpu_data  = 8'o252;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("reset_tx_start_%0d", i), int'(tx_start), 0);
        end
        checkOutput("reset_cpu_ready", int'(cpu_ready), 1);
        checkOutput("reset_dbg_ready", int'(dbg_ready), 1);
        checkOutput("reset_tx_data", int'(tx_data), 0);
        checkOutput("reset_owner", int'(owner), 0);
        checkOutput("reset_cpu_done", int'(cpu_done), 0);
        checkOutput("reset_dbg_done", int'(dbg_done), 0);
        checkOutput("reset_tx_err", int'(tx_err), 0);
        cpu_valid = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        checkOutput("post_reset_no_start", n_start, 0);

        // Arbitration table.
        tx_len = 5;
        for (int i = 0; i < 6; i++) begin
            s0 = n_start;
            applyStimulus(vec[i].cv, vec[i].cd, vec[i].dv, vec[i].dd);
            waitStarts(s0 + 1, 100, $sformatf("vec%0d_start0", i));
            checkOutput($sformatf("vec%0d_owner0", i), int'(start_owner), int'(vec[i].o0));
            checkOutput($sformatf("vec%0d_data0", i), int'(start_data), int'(vec[i].d0));
            if (vec[i].nl > 1) begin
                waitStarts(s0 + 2, 100, $sformatf("vec%0d_start1", i));
                checkOutput($sformatf("vec%0d_owner1", i), int'(start_owner), int'(vec[i].o1));
                checkOutput($sformatf("vec%0d_data1", i), int'(start_data), int'(vec[i].d1));
            end
            waitQuiet($sformatf("vec%0d_quiet", i));
            checkOutput($sformatf("vec%0d_launches", i), n_start - s0, vec[i].nl);
        end

        // Single CPU character with a long transmission.
        tx_len = 100;
        s0 = n_start;
        c0 = n_cpu_done;
        d0 = n_dbg_done;
        k0 = cyc;
        applyStimulus(1'b1, 8'o252, 1'b0, 8'o000);
        checkOutput("single_cpu_ready_low", int'(cpu_ready), 0);
        waitStarts(s0 + 1, 20, "single_start");
        checkOutput("single_start_cycle", t_start - k0, 3);
        checkOutput("single_data", int'(start_data), 8'o252);
        checkOutput("single_owner", int'(start_owner), 0);
        waitCpuDone(c0 + 1, 200, "single_done");
        checkOutput("single_done_cycle", t_cpu_done - t_start, 102);
        waitQuiet("single_quiet");
        checkOutput("single_cpu_done_count", n_cpu_done - c0, 1);
        checkOutput("single_dbg_done_count", n_dbg_done - d0, 0);

        // Back-to-back CPU characters: gap from done to next launch.
        tx_len = 5;
        s0 = n_start;
        c0 = n_cpu_done;
        applyStimulus(1'b1, 8'o141, 1'b0, 8'o000);
        waitStarts(s0 + 1, 20, "gap_start0");
        applyStimulus(1'b1, 8'o142, 1'b0, 8'o000);
        waitCpuDone(c0 + 1, 50, "gap_done0");
        td = t_cpu_done;
        waitStarts(s0 + 2, 50, "gap_start1");
        checkOutput("gap_done_to_start", t_start - td, GAP + 2);
        checkOutput("gap_data1", int'(start_data), 8'o142);
        waitQuiet("gap_quiet");

        // Transmitter never raises busy: timeout path, then the next character is served.
        tie_low = 1'b1;
        s0 = n_start;
        c0 = n_cpu_done;
        d0 = n_dbg_done;
        e0 = n_err;
        applyStimulus(1'b1, 8'o123, 1'b0, 8'o000);
        waitStarts(s0 + 1, 20, "tmo_start0");
        applyStimulus(1'b0, 8'o000, 1'b1, 8'o321);
        waitErr(e0 + 1, 40, "tmo_err0");
        checkOutput("tmo_err_delay", t_err - t_start, TMO);
        checkOutput("tmo_cpu_done_with_err", t_cpu_done, t_err);
        checkOutput("tmo_cpu_done_count", n_cpu_done - c0, 1);
        waitStarts(s0 + 2, 60, "tmo_start1");
        checkOutput("tmo_next_owner", int'(start_owner), 1);
        checkOutput("tmo_next_data", int'(start_data), 8'o321);
        waitErr(e0 + 2, 40, "tmo_err1");
        checkOutput("tmo_dbg_done_with_err", t_dbg_done, t_err);
        waitQuiet("tmo_quiet");
        tie_low = 1'b0;

        // Reset while transmitting with a debug character pending.
        tx_len = 100;
        s0 = n_start;
        applyStimulus(1'b1, 8'o007, 1'b0, 8'o000);
        waitStarts(s0 + 1, 20, "mid_start");
        repeat (5) tick();
        applyStimulus(1'b0, 8'o000, 1'b1, 8'o077);
        checkOutput("mid_dbg_ready_low", int'(dbg_ready), 0);
        c0 = n_cpu_done;
        d0 = n_dbg_done;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("mid_dbg_ready", int'(dbg_ready), 1);
        checkOutput("mid_cpu_ready", int'(cpu_ready), 1);
        repeat (150) tick();
        checkOutput("mid_no_cpu_done", n_cpu_done - c0, 0);
        checkOutput("mid_no_dbg_done", n_dbg_done - d0, 0);
        checkOutput("mid_no_relaunch", n_start - s0, 1);

        // Randomized traffic against a queue-level reference model.
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        both_prev  = 1'b0;
        prev_owner = 1'b1;
        last_done  = -1000;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (tx_start) begin
                if (both_prev)
                    checkOutput("rand_alternate", int'(owner), int'(!prev_owner));
                prev_owner = owner;
                if (owner == 1'b0) begin
                    if (cpu_q.size() == 0) begin
                        expiredBound("rand_cpu_launch_without_char");
                        exp_data = '0;
                    end else begin
                        exp_data = cpu_q.pop_front();
                    end
                end else begin
                    if (dbg_q.size() == 0) begin
                        expiredBound("rand_dbg_launch_without_char");
                        exp_data = '0;
                    end else begin
                        exp_data = dbg_q.pop_front();
                    end
                end
                checkOutput("rand_tx_data", int'(tx_data), int'(exp_data));
                if (cyc - last_done < GAP + 2)
                    checkOutput("rand_gap", cyc - last_done, GAP + 2);
                done_own_q.push_back(owner);
                done_cyc_q.push_back(cyc + tx_len + 2);
            end
            if (cpu_done || dbg_done) begin
                checkOutput("rand_single_done", int'(cpu_done) + int'(dbg_done), 1);
                if (done_cyc_q.size() == 0) begin
                    expiredBound("rand_unexpected_done");
                end else begin
                    checkOutput("rand_done_owner", int'(dbg_done), int'(done_own_q.pop_front()));
                    checkOutput("rand_done_cycle", cyc, done_cyc_q.pop_front());
                end
                last_done = cyc;
            end
            if (tx_err) checkOutput("rand_tx_err", int'(tx_err), 0);
            checkOutput("rand_cpu_ready", int'(cpu_ready), int'(cpu_q.size() == 0));
            checkOutput("rand_dbg_ready", int'(dbg_ready), int'(dbg_q.size() == 0));
            both_prev = (cpu_q.size() != 0) && (dbg_q.size() != 0);
            if (cpu_valid && cpu_ready) cpu_q.push_back(cpu_data);
            if (dbg_valid && dbg_ready) dbg_q.push_back(dbg_data);
            @(posedge clk);
            #1;
            if (c < 2850) begin
                cpu_valid = ($urandom_range(0, 9) < 3);
                cpu_data  = 8'($urandom);
                dbg_valid = ($urandom_range(0, 9) < 3);
                dbg_data  = 8'($urandom);
            end else begin
                cpu_valid = 1'b0;
                dbg_valid = 1'b0;
            end
            tx_len = $urandom_range(1, 20);
        end
        checkOutput("rand_cpu_drained", cpu_q.size(), 0);
        checkOutput("rand_dbg_drained", dbg_q.size(), 0);
        checkOutput("rand_dones_drained", done_cyc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
